// File: rtl/wb_arbiter_if.sv
// Bundle of the six result-source handshakes and the four register-file write
// ports between the execution units and the writeback arbiter.
interface wb_arbiter_if #(
    parameter int WIDTH = 5
);
    logic             i_valid0, i_valid1, i_valid2, i_valid3, i_valid4, i_valid5;
    logic             o_ready0, o_ready1, o_ready2, o_ready3, o_ready4, o_ready5;
    logic [WIDTH-1:0] i_addr0, i_addr1, i_addr2, i_addr3, i_addr4, i_addr5;
    logic [31:0]      i_data0, i_data1, i_data2, i_data3, i_data4, i_data5;
    logic             o_we0, o_we1, o_we2, o_we3;
    logic [WIDTH-1:0] o_waddr0, o_waddr1, o_waddr2, o_waddr3;
    logic [31:0]      o_wdata0, o_wdata1, o_wdata2, o_wdata3;
    logic             o_idle;

    modport master (
        output i_valid0, i_valid1, i_valid2, i_valid3, i_valid4, i_valid5,
        output i_addr0, i_addr1, i_addr2, i_addr3, i_addr4, i_addr5,
        output i_data0, i_data1, i_data2, i_data3, i_data4, i_data5,
        input  o_ready0, o_ready1, o_ready2, o_ready3, o_ready4, o_ready5,
        input  o_we0, o_we1, o_we2, o_we3,
        input  o_waddr0, o_waddr1, o_waddr2, o_waddr3,
        input  o_wdata0, o_wdata1, o_wdata2, o_wdata3,
        input  o_idle
    );

    modport slave (
        input  i_valid0, i_valid1, i_valid2, i_valid3, i_valid4, i_valid5,
        input  i_addr0, i_addr1, i_addr2, i_addr3, i_addr4, i_addr5,
        input  i_data0, i_data1, i_data2, i_data3, i_data4, i_data5,
        output o_ready0, o_ready1, o_ready2, o_ready3, o_ready4, o_ready5,
        output o_we0, o_we1, o_we2, o_we3,
        output o_waddr0, o_waddr1, o_waddr2, o_waddr3,
        output o_wdata0, o_wdata1, o_wdata2, o_wdata3,
        output o_idle
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: six per-source FIFOs drained onto four register-file write
// ports with rotating priority and same-address conflict deferral.
module wb_arbiter #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    wb_arbiter_if.slave bus
);
    localparam int NSRC  = 6;
    localparam int NPORT = 4;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [NSRC-1:0]  valid, ready, push, pop;
    logic [WIDTH-1:0] in_addr [NSRC];
    logic [31:0]      in_data [NSRC];

    assign valid = {bus.i_valid5, bus.i_valid4, bus.i_valid3,
                    bus.i_valid2, bus.i_valid1, bus.i_valid0};
    assign in_addr[0] = bus.i_addr0;  assign in_data[0] = bus.i_data0;
    assign in_addr[1] = bus.i_addr1;  assign in_data[1] = bus.i_data1;
    assign in_addr[2] = bus.i_addr2;  assign in_data[2] = bus.i_data2;
    assign in_addr[3] = bus.i_addr3;  assign in_data[3] = bus.i_data3;
    assign in_addr[4] = bus.i_addr4;  assign in_data[4] = bus.i_data4;
    assign in_addr[5] = bus.i_addr5;  assign in_data[5] = bus.i_data5;

    logic [WIDTH-1:0] mem_addr  [NSRC][DEPTH];
    logic [31:0]      mem_data  [NSRC][DEPTH];
    logic [PW-1:0]    wptr      [NSRC];
    logic [PW-1:0]    rptr      [NSRC];
    logic [CW-1:0]    cnt       [NSRC];
    logic [WIDTH-1:0] head_addr [NSRC];
    logic [31:0]      head_data [NSRC];

    // Ready depends only on the registered count, so a full FIFO stays closed
    // even on a cycle where it is also being drained.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            ready[s]     = (cnt[s] < CW'(DEPTH));
            push[s]      = valid[s] & ready[s];
            head_addr[s] = mem_addr[s][rptr[s]];
            head_data[s] = mem_data[s][rptr[s]];
        end
    end

    assign bus.o_ready0 = ready[0];
    assign bus.o_ready1 = ready[1];
    assign bus.o_ready2 = ready[2];
    assign bus.o_ready3 = ready[3];
    assign bus.o_ready4 = ready[4];
    assign bus.o_ready5 = ready[5];

    logic [2:0]       rr, rr_next, ngrant, scan_src;
    logic [3:0]       scan_sum;
    logic             conflict;
    logic [NPORT-1:0] sel_vld, sel_we;
    logic [WIDTH-1:0] sel_addr [NPORT];
    logic [31:0]      sel_data [NPORT];

    // p0: scan heads from rr; grants fill ports in scan order.
    always_comb begin
        pop      = '0;
        ngrant   = '0;
        rr_next  = rr;
        sel_vld  = '0;
        sel_we   = '0;
        scan_sum = '0;
        scan_src = '0;
        conflict = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            sel_addr[k] = '0;
            sel_data[k] = '0;
        end
        for (int i = 0; i < NSRC; i++) begin
            scan_sum = {1'b0, rr} + 4'(i);
            if (scan_sum >= 4'd6) scan_sum = scan_sum - 4'd6;
            scan_src = scan_sum[2:0];
            conflict = 1'b0;
            // Only real writes (nonzero address) can block a later head.
            for (int j = 0; j < NPORT; j++)
                if (sel_vld[j] && sel_we[j] && sel_addr[j] == head_addr[scan_src])
                    conflict = 1'b1;
            if (cnt[scan_src] != '0 && ngrant < 3'd4 && !conflict) begin
                pop[scan_src]           = 1'b1;
                sel_vld[ngrant[1:0]]    = 1'b1;
                sel_we[ngrant[1:0]]     = |head_addr[scan_src];
                sel_addr[ngrant[1:0]]   = head_addr[scan_src];
                sel_data[ngrant[1:0]]   = head_data[scan_src];
                ngrant                  = ngrant + 3'd1;
                rr_next                 = (scan_src == 3'd5) ? 3'd0 : scan_src + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr <= '0;
            for (int s = 0; s < NSRC; s++) begin
                wptr[s] <= '0;
                rptr[s] <= '0;
                cnt[s]  <= '0;
            end
        end else begin
            rr <= rr_next;
            for (int s = 0; s < NSRC; s++) begin
                if (push[s]) wptr[s] <= wptr[s] + PW'(1);
                if (pop[s])  rptr[s] <= rptr[s] + PW'(1);
                cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                mem_addr[s][wptr[s]] <= in_addr[s];
                mem_data[s][wptr[s]] <= in_data[s];
            end
        end
    end

    // p1: granted slots, one cycle before they reach the write ports.
    logic [NPORT-1:0] vld_p1, we_p1;
    logic [WIDTH-1:0] addr_p1 [NPORT];
    logic [31:0]      data_p1 [NPORT];

    always_ff @(posedge i_clk) begin
        if (i_rst) vld_p1 <= '0;
        else       vld_p1 <= sel_vld;
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NPORT; k++) begin
            if (sel_vld[k]) begin
                we_p1[k]   <= sel_we[k];
                addr_p1[k] <= sel_addr[k];
                data_p1[k] <= sel_data[k];
            end
        end
    end

    // p2: register-file write ports; unused ports hold their last addr/data.
    logic [NPORT-1:0] we_p2;
    logic [WIDTH-1:0] waddr_p2 [NPORT];
    logic [31:0]      wdata_p2 [NPORT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_p2 <= '0;
            for (int k = 0; k < NPORT; k++) begin
                waddr_p2[k] <= '0;
                wdata_p2[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                if (vld_p1[k]) begin
                    we_p2[k]    <= we_p1[k];
                    waddr_p2[k] <= addr_p1[k];
                    wdata_p2[k] <= data_p1[k];
                end else begin
                    we_p2[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.o_we0 = we_p2[0];  assign bus.o_waddr0 = waddr_p2[0];  assign bus.o_wdata0 = wdata_p2[0];
    assign bus.o_we1 = we_p2[1];  assign bus.o_waddr1 = waddr_p2[1];  assign bus.o_wdata1 = wdata_p2[1];
    assign bus.o_we2 = we_p2[2];  assign bus.o_waddr2 = waddr_p2[2];  assign bus.o_wdata2 = wdata_p2[2];
    assign bus.o_we3 = we_p2[3];  assign bus.o_waddr3 = waddr_p2[3];  assign bus.o_wdata3 = wdata_p2[3];

    // Idle also waits for granted slots still in flight between p0 and p2.
    logic idle;
    always_comb begin
        idle = ~|we_p2 & ~|vld_p1;
        for (int s = 0; s < NSRC; s++)
            if (cnt[s] != '0) idle = 1'b0;
    end

    assign bus.o_idle = idle;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed per-cycle vectors plus a per-source scoreboard
// under backpressure and random traffic.
module tb_wb_arbiter;
    localparam int W = 5;

    typedef logic [5:0][W-1:0] a6_t;
    typedef logic [5:0][31:0]  d6_t;
    typedef logic [3:0][W-1:0] a4_t;
    typedef logic [3:0][31:0]  d4_t;

    typedef struct {
        string      name;
        logic       r;
        logic [5:0] v;
        a6_t        a;
        d6_t        d;
        logic [3:0] we;
        a4_t        wa;
        d4_t        wd;
        logic       idle;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [31:0]  d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.WIDTH(W)) bus ();
    wb_arbiter #(.WIDTH(W), .DEPTH(2)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int         n_chk = 0;
    int         n_pass = 0;
    vec_t       vecs[$];
    ent_t       sbq[6][$];
    bit         sb_on = 1'b0;
    int         seq = 0;
    logic [5:0] cur_v;
    a6_t        cur_a;
    d6_t        cur_d;

    function automatic logic [3:0] get_we();
        return {bus.o_we3, bus.o_we2, bus.o_we1, bus.o_we0};
    endfunction
    function automatic a4_t get_waddr();
        return {bus.o_waddr3, bus.o_waddr2, bus.o_waddr1, bus.o_waddr0};
    endfunction
    function automatic d4_t get_wdata();
        return {bus.o_wdata3, bus.o_wdata2, bus.o_wdata1, bus.o_wdata0};
    endfunction
    function automatic logic [5:0] get_ready();
        return {bus.o_ready5, bus.o_ready4, bus.o_ready3, bus.o_ready2, bus.o_ready1, bus.o_ready0};
    endfunction

    task automatic set_inputs(input logic [5:0] v, input a6_t a, input d6_t d);
        cur_v = v; cur_a = a; cur_d = d;
        bus.i_valid0 = v[0]; bus.i_addr0 = a[0]; bus.i_data0 = d[0];
        bus.i_valid1 = v[1]; bus.i_addr1 = a[1]; bus.i_data1 = d[1];
        bus.i_valid2 = v[2]; bus.i_addr2 = a[2]; bus.i_data2 = d[2];
        bus.i_valid3 = v[3]; bus.i_addr3 = a[3]; bus.i_data3 = d[3];
        bus.i_valid4 = v[4]; bus.i_addr4 = a[4]; bus.i_data4 = d[4];
        bus.i_valid5 = v[5]; bus.i_addr5 = a[5]; bus.i_data5 = d[5];
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input string nm, input logic r, input logic [5:0] v, input a6_t a,
                        input d6_t d, input logic [3:0] we, input a4_t wa, input d4_t wd,
                        input logic idle);
        vec_t x;
        x.name = nm; x.r = r; x.v = v; x.a = a; x.d = d;
        x.we = we; x.wa = wa; x.wd = wd; x.idle = idle;
        vecs.push_back(x);
    endtask

    task automatic sb_check();
        logic [3:0] we;
        a4_t        wa;
        d4_t        wd;
        int         src;
        ent_t       e;
        bit         ok;
        we = get_we(); wa = get_waddr(); wd = get_wdata();
        if (we != 4'd0) begin
            ok = (we == 4'b0001 || we == 4'b0011 || we == 4'b0111 || we == 4'b1111);
            chk("ports_packed", {127'd0, ok}, 128'd1);
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    src = int'(wd[k][31:28]);
                    ok = 1'b0;
                    e.a = '0; e.d = '0;
                    if (src < 6 && sbq[src].size() > 0) begin
                        e = sbq[src].pop_front();
                        ok = (e.a == wa[k] && e.d == wd[k]);
                    end
                    chk("sb_write", {91'd0, wa[k], wd[k]}, ok ? {91'd0, wa[k], wd[k]} : {91'd0, e.a, e.d});
                end
            end
            ok = 1'b1;
            for (int j = 0; j < 4; j++)
                for (int k = j + 1; k < 4; k++)
                    if (we[j] && we[k] && wa[j] == wa[k]) ok = 1'b0;
            chk("addr_unique", {127'd0, ok}, 128'd1);
        end
    endtask

    task automatic step();
        logic [5:0] rdy;
        rdy = get_ready();
        if (sb_on && !rst)
            for (int s = 0; s < 6; s++)
                if (cur_v[s] && rdy[s]) sbq[s].push_back('{cur_a[s], cur_d[s]});
        tick();
        if (sb_on) sb_check();
    endtask

    task automatic drain(input string nm);
        int left;
        set_inputs('0, '0, '0);
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.o_idle) break;
        end
        chk({nm, "_idle"}, {127'd0, bus.o_idle}, 128'd1);
        left = 0;
        for (int s = 0; s < 6; s++) left += sbq[s].size();
        chk({nm, "_left"}, 128'(left), 128'd0);
    endtask

    task automatic rand_inputs(input bit all_valid);
        logic [5:0] v;
        a6_t        a;
        d6_t        d;
        for (int s = 0; s < 6; s++) begin
            v[s] = all_valid ? 1'b1 : ($urandom_range(0, 9) < 7);
            a[s] = all_valid ? W'(s + 1) : W'($urandom_range(1, 7));
            d[s] = {4'(s), 28'(seq)};
            seq++;
        end
        set_inputs(v, a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit bp_seen;
        rst = 1'b1;
        set_inputs(6'b000001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1});

        // Reset held two cycles with a source asserting valid.
        tick(); tick();
        chk("rst_we", 128'(get_we()), 128'd0);
        chk("rst_ready", 128'(get_ready()), 128'h3F);
        chk("rst_idle", {127'd0, bus.o_idle}, 128'd1);
        chk("rst_waddr", 128'(get_waddr()), 128'd0);
        rst = 1'b0;
        set_inputs('0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_we", 128'(get_we()), 128'd0);
        end
        chk("post_rst_idle", {127'd0, bus.o_idle}, 128'd1);

        addv("single_push",  1'b0, 6'b000100, {5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0},
             {32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0}, 4'b0000, '0, '0, 1'b0);
        addv("single_pipe",  1'b0, 6'b0, '0, '0, 4'b0000, '0, '0, 1'b0);
        addv("single_write", 1'b0, 6'b0, '0, '0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5},
             {32'd0, 32'd0, 32'd0, 32'hDEADBEEF}, 1'b0);
        addv("single_done",  1'b0, 6'b0, '0, '0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd5},
             {32'd0, 32'd0, 32'd0, 32'hDEADBEEF}, 1'b1);
        addv("six_rst",      1'b1, 6'b0, '0, '0, 4'b0000, '0, '0, 1'b1);
        addv("six_push",     1'b0, 6'b111111, {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
             {32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100}, 4'b0000, '0, '0, 1'b0);
        addv("six_pipe",     1'b0, 6'b0, '0, '0, 4'b0000, '0, '0, 1'b0);
        addv("six_w1",       1'b0, 6'b0, '0, '0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
             {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0);
        addv("six_w2",       1'b0, 6'b0, '0, '0, 4'b0011, {5'd4, 5'd3, 5'd6, 5'd5},
             {32'h103, 32'h102, 32'h105, 32'h104}, 1'b0);
        addv("six_done",     1'b0, 6'b0, '0, '0, 4'b0000, {5'd4, 5'd3, 5'd6, 5'd5},
             {32'h103, 32'h102, 32'h105, 32'h104}, 1'b1);
        addv("cf_rst",       1'b1, 6'b0, '0, '0, 4'b0000, '0, '0, 1'b1);
        addv("cf_push",      1'b0, 6'b000011, {5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd7},
             {32'd0, 32'd0, 32'd0, 32'd0, 32'h22, 32'h11}, 4'b0000, '0, '0, 1'b0);
        addv("cf_pipe",      1'b0, 6'b0, '0, '0, 4'b0000, '0, '0, 1'b0);
        addv("cf_w1",        1'b0, 6'b0, '0, '0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7},
             {32'd0, 32'd0, 32'd0, 32'h11}, 1'b0);
        addv("cf_w2",        1'b0, 6'b0, '0, '0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7},
             {32'd0, 32'd0, 32'd0, 32'h22}, 1'b0);
        addv("cf_done",      1'b0, 6'b0, '0, '0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd7},
             {32'd0, 32'd0, 32'd0, 32'h22}, 1'b1);
        addv("z_rst",        1'b1, 6'b0, '0, '0, 4'b0000, '0, '0, 1'b1);
        addv("z_push",       1'b0, 6'b000010, '0,
             {32'd0, 32'd0, 32'd0, 32'd0, 32'hABCD, 32'd0}, 4'b0000, '0, '0, 1'b0);
        addv("z_pipe",       1'b0, 6'b0, '0, '0, 4'b0000, '0, '0, 1'b0);
        addv("z_slot",       1'b0, 6'b0, '0, '0, 4'b0000, '0, {32'd0, 32'd0, 32'd0, 32'hABCD}, 1'b1);
        addv("z_done",       1'b0, 6'b0, '0, '0, 4'b0000, '0, {32'd0, 32'd0, 32'd0, 32'hABCD}, 1'b1);

        foreach (vecs[i]) begin
            rst = vecs[i].r;
            set_inputs(vecs[i].v, vecs[i].a, vecs[i].d);
            tick();
            chk({vecs[i].name, "_we"}, 128'(get_we()), 128'(vecs[i].we));
            chk({vecs[i].name, "_waddr"}, 128'(get_waddr()), 128'(vecs[i].wa));
            chk({vecs[i].name, "_wdata"}, 128'(get_wdata()), 128'(vecs[i].wd));
            chk({vecs[i].name, "_idle"}, {127'd0, bus.o_idle}, {127'd0, vecs[i].idle});
            chk({vecs[i].name, "_ready"}, 128'(get_ready()), 128'h3F);
        end
        rst = 1'b0;

        // Backpressure: six sources saturating four ports must fill source 3.
        rst = 1'b1; set_inputs('0, '0, '0); tick(); rst = 1'b0;
        sb_on = 1'b1;
        bp_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            rand_inputs(1'b1);
            if (!get_ready()[3]) bp_seen = 1'b1;
            step();
        end
        chk("bp_ready3_low", {127'd0, bp_seen}, 128'd1);
        drain("bp_drain");

        // Random traffic over a small address set to provoke conflicts.
        for (int c = 0; c < 300; c++) begin
            rand_inputs(1'b0);
            step();
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
